// File: rtl/siphash_pkg.sv
// Shared constants and types for the parametrised SipHash core.
// Consumers: siphash_round, siphash_pcore.
package siphash_pkg;

    localparam logic [63:0] IV0 = 64'h736f6d6570736575;
    localparam logic [63:0] IV1 = 64'h646f72616e646f6d;
    localparam logic [63:0] IV2 = 64'h6c7967656e657261;
    localparam logic [63:0] IV3 = 64'h7465646279746573;

    localparam logic [63:0] TWEAK_LONG_INIT = 64'hee;
    localparam logic [63:0] TWEAK_FIN_LONG  = 64'hee;
    localparam logic [63:0] TWEAK_FIN_SHORT = 64'hff;
    localparam logic [63:0] TWEAK_FIN2      = 64'hdd;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMP,
        ST_COMP_END,
        ST_FIN,
        ST_FIN_END,
        ST_FIN2,
        ST_FIN2_END
    } state_t;

    typedef struct packed {
        logic [63:0] v0;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [63:0] v3;
    } sipround_t;

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

endpackage

// File: rtl/siphash_round.sv
// One combinational SipRound over the four-word SipHash state.
module siphash_round
    import siphash_pkg::*;
(
    input  sipround_t s_in,
    output sipround_t s_out
);

    logic [63:0] a, b, c, d;

    always_comb begin
        a = s_in.v0;
        b = s_in.v1;
        c = s_in.v2;
        d = s_in.v3;

        a = a + b;  b = rotl64(b, 13);  b = b ^ a;  a = rotl64(a, 32);
        c = c + d;  d = rotl64(d, 16);  d = d ^ c;
        a = a + d;  d = rotl64(d, 21);  d = d ^ a;
        c = c + b;  b = rotl64(b, 17);  b = b ^ c;  c = rotl64(c, 32);

        s_out.v0 = a;
        s_out.v1 = b;
        s_out.v2 = c;
        s_out.v3 = d;
    end

endmodule

// File: rtl/siphash_pcore.sv
// SipHash core applying up to ROUNDS_PER_CYCLE SipRounds per clock.
// Define SIPHASH_128_EN to enable the 128-bit output mode (second finalization pass).
module siphash_pcore
    import siphash_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         initalize,
    input  logic         mi_valid,
    input  logic [63:0]  mi,
    output logic         mi_ready,
    input  logic         finalize,
    input  logic         long,
    input  logic [3:0]   compression_rounds,
    input  logic [3:0]   final_rounds,
    input  logic [127:0] key,
    output logic         ready,
    output logic [127:0] siphash_word,
    output logic         siphash_word_valid
);

    localparam logic [3:0] P_ROUNDS = 4'(ROUNDS_PER_CYCLE);

    state_t      state_reg, state_next;
    sipround_t   v_reg, v_next;
    logic [63:0] mi_reg, mi_next;
    logic [63:0] word_lo_reg, word_lo_next;
    logic [3:0]  rem_reg, rem_next;
    logic [3:0]  d_reg, d_next;
    logic [3:0]  step;
    logic        long_reg, long_next, long_eff;
    logic        valid_reg, valid_next;
    logic [63:0] v_fold;

    sipround_t chain   [0:ROUNDS_PER_CYCLE];
    sipround_t rnd_out [0:ROUNDS_PER_CYCLE-1];

`ifdef SIPHASH_128_EN
    logic [63:0] word_hi_reg, word_hi_next;
    assign long_eff     = long;
    assign siphash_word = {word_hi_reg, word_lo_reg};
`else
    logic unused_long;
    assign unused_long  = long;
    assign long_eff     = 1'b0;
    assign siphash_word = {64'h0, word_lo_reg};
`endif

    assign ready              = (state_reg == ST_IDLE);
    assign mi_ready           = ready;
    assign siphash_word_valid = valid_reg;
    assign v_fold             = v_reg.v0 ^ v_reg.v1 ^ v_reg.v2 ^ v_reg.v3;
    assign step               = (rem_reg > P_ROUNDS) ? P_ROUNDS : rem_reg;

    // Stage gi runs only while gi < min(P, rem); since gi < P always, gi < rem suffices.
    assign chain[0] = v_reg;
    for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_stage
        siphash_round u_round (
            .s_in  (chain[gi]),
            .s_out (rnd_out[gi])
        );
        assign chain[gi+1] = (rem_reg > 4'(gi)) ? rnd_out[gi] : chain[gi];
    end

    always_comb begin
        state_next   = state_reg;
        v_next       = v_reg;
        mi_next      = mi_reg;
        rem_next     = rem_reg;
        d_next       = d_reg;
        long_next    = long_reg;
        valid_next   = valid_reg;
        word_lo_next = word_lo_reg;
`ifdef SIPHASH_128_EN
        word_hi_next = word_hi_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (initalize) begin
                    v_next.v0  = key[63:0]   ^ IV0;
                    v_next.v1  = key[127:64] ^ IV1 ^ (long_eff ? TWEAK_LONG_INIT : 64'h0);
                    v_next.v2  = key[63:0]   ^ IV2;
                    v_next.v3  = key[127:64] ^ IV3;
                    long_next  = long_eff;
                    valid_next = 1'b0;
                end else if (mi_valid) begin
                    v_next.v3  = v_reg.v3 ^ mi;
                    mi_next    = mi;
                    rem_next   = compression_rounds;
                    state_next = (compression_rounds == 4'd0) ? ST_COMP_END : ST_COMP;
                end else if (finalize) begin
                    v_next.v2  = v_reg.v2 ^ (long_reg ? TWEAK_FIN_LONG : TWEAK_FIN_SHORT);
                    d_next     = final_rounds;
                    rem_next   = final_rounds;
                    valid_next = 1'b0;
                    state_next = (final_rounds == 4'd0) ? ST_FIN_END : ST_FIN;
                end
            end
            ST_COMP, ST_FIN: begin
                v_next   = chain[ROUNDS_PER_CYCLE];
                rem_next = rem_reg - step;
                if (rem_next == 4'd0)
                    state_next = (state_reg == ST_COMP) ? ST_COMP_END : ST_FIN_END;
            end
            ST_COMP_END: begin
                v_next.v0  = v_reg.v0 ^ mi_reg;
                state_next = ST_IDLE;
            end
            ST_FIN_END: begin
                word_lo_next = v_fold;
`ifdef SIPHASH_128_EN
                if (long_reg) begin
                    v_next.v1  = v_reg.v1 ^ TWEAK_FIN2;
                    rem_next   = d_reg;
                    state_next = (d_reg == 4'd0) ? ST_FIN2_END : ST_FIN2;
                end else begin
                    word_hi_next = 64'h0;
                    valid_next   = 1'b1;
                    state_next   = ST_IDLE;
                end
`else
                valid_next = 1'b1;
                state_next = ST_IDLE;
`endif
            end
`ifdef SIPHASH_128_EN
            ST_FIN2: begin
                v_next   = chain[ROUNDS_PER_CYCLE];
                rem_next = rem_reg - step;
                if (rem_next == 4'd0)
                    state_next = ST_FIN2_END;
            end
            ST_FIN2_END: begin
                word_hi_next = v_fold;
                valid_next   = 1'b1;
                state_next   = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            v_reg       <= '0;
            mi_reg      <= '0;
            rem_reg     <= '0;
            d_reg       <= '0;
            long_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            word_lo_reg <= '0;
`ifdef SIPHASH_128_EN
            word_hi_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            v_reg       <= v_next;
            mi_reg      <= mi_next;
            rem_reg     <= rem_next;
            d_reg       <= d_next;
            long_reg    <= long_next;
            valid_reg   <= valid_next;
            word_lo_reg <= word_lo_next;
`ifdef SIPHASH_128_EN
            word_hi_reg <= word_hi_next;
`endif
        end
    end

endmodule

// File: tb/tb_siphash_pcore.sv
// Bench for siphash_pcore: three instances (P=1,3,4) share stimulus; digests are scoreboarded
// against a behavioural SipHash model and the published test vectors.
module tb_siphash_pcore;

    localparam logic [127:0] KEY_STD = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KEY_ALT = 128'h1f2e3d4c5b6a7988_0123456789abcdef;
`ifdef SIPHASH_128_EN
    localparam bit EN128 = 1'b1;
`else
    localparam bit EN128 = 1'b0;
`endif
    localparam int NI = 3;

    int pv [NI] = '{1, 3, 4};

    logic         clk = 1'b0;
    logic         reset_n, initalize, mi_valid, finalize, long;
    logic [63:0]  mi;
    logic [3:0]   compression_rounds, final_rounds;
    logic [127:0] key;
    logic         rdy  [NI];
    logic         mrdy [NI];
    logic         vld  [NI];
    logic [127:0] word [NI];

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_q [$];
    logic [127:0] last_exp;
    logic [63:0]  mv [4];
    bit           m_long;

    always #5 clk = ~clk;

    siphash_pcore #(.ROUNDS_PER_CYCLE(1)) u_p1 (
        .clk(clk), .reset_n(reset_n), .initalize(initalize), .mi_valid(mi_valid), .mi(mi),
        .mi_ready(mrdy[0]), .finalize(finalize), .long(long),
        .compression_rounds(compression_rounds), .final_rounds(final_rounds), .key(key),
        .ready(rdy[0]), .siphash_word(word[0]), .siphash_word_valid(vld[0]));
    siphash_pcore #(.ROUNDS_PER_CYCLE(3)) u_p3 (
        .clk(clk), .reset_n(reset_n), .initalize(initalize), .mi_valid(mi_valid), .mi(mi),
        .mi_ready(mrdy[1]), .finalize(finalize), .long(long),
        .compression_rounds(compression_rounds), .final_rounds(final_rounds), .key(key),
        .ready(rdy[1]), .siphash_word(word[1]), .siphash_word_valid(vld[1]));
    siphash_pcore #(.ROUNDS_PER_CYCLE(4)) u_p4 (
        .clk(clk), .reset_n(reset_n), .initalize(initalize), .mi_valid(mi_valid), .mi(mi),
        .mi_ready(mrdy[2]), .finalize(finalize), .long(long),
        .compression_rounds(compression_rounds), .final_rounds(final_rounds), .key(key),
        .ready(rdy[2]), .siphash_word(word[2]), .siphash_word_valid(vld[2]));

    // ---------------- reference model ----------------
    function automatic logic [63:0] rl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic void m_round();
        mv[0] = mv[0] + mv[1]; mv[1] = rl(mv[1], 13); mv[1] = mv[1] ^ mv[0]; mv[0] = rl(mv[0], 32);
        mv[2] = mv[2] + mv[3]; mv[3] = rl(mv[3], 16); mv[3] = mv[3] ^ mv[2];
        mv[0] = mv[0] + mv[3]; mv[3] = rl(mv[3], 21); mv[3] = mv[3] ^ mv[0];
        mv[2] = mv[2] + mv[1]; mv[1] = rl(mv[1], 17); mv[1] = mv[1] ^ mv[2]; mv[2] = rl(mv[2], 32);
    endfunction

    function automatic void m_init(input logic [127:0] k, input bit lg);
        mv[0] = k[63:0]   ^ 64'h736f6d6570736575;
        mv[1] = k[127:64] ^ 64'h646f72616e646f6d ^ (lg ? 64'hee : 64'h0);
        mv[2] = k[63:0]   ^ 64'h6c7967656e657261;
        mv[3] = k[127:64] ^ 64'h7465646279746573;
        m_long = lg;
    endfunction

    function automatic void m_compress(input logic [63:0] m, input int c);
        mv[3] = mv[3] ^ m;
        for (int r = 0; r < c; r++) m_round();
        mv[0] = mv[0] ^ m;
    endfunction

    function automatic logic [127:0] m_finalize(input int d);
        logic [63:0] lo, hi;
        mv[2] = mv[2] ^ (m_long ? 64'hee : 64'hff);
        for (int r = 0; r < d; r++) m_round();
        lo = mv[0] ^ mv[1] ^ mv[2] ^ mv[3];
        hi = 64'h0;
        if (m_long) begin
            mv[1] = mv[1] ^ 64'hdd;
            for (int r = 0; r < d; r++) m_round();
            hi = mv[0] ^ mv[1] ^ mv[2] ^ mv[3];
        end
        return {hi, lo};
    endfunction

    function automatic int busy_of(input int rounds, input int p);
        return (rounds + p - 1) / p + 1;
    endfunction

    // ---------------- stimulus (tasks start and end at posedge+1) ----------------
    task automatic wait_idle(output int busy [NI]);
        bit done = 1'b0;
        for (int i = 0; i < NI; i++) busy[i] = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = 1'b1;
            for (int i = 0; i < NI; i++)
                if (!rdy[i]) begin busy[i]++; done = 1'b0; end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL idle_timeout: got ready still low after 300 cycles, want ready=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic do_init(input logic [127:0] k, input bit lg);
        key = k; long = lg; initalize = 1'b1;
        @(posedge clk); #1;
        initalize = 1'b0;
        m_init(k, EN128 && lg);
    endtask

    task automatic do_word(input logic [63:0] m, input logic [3:0] c, output int busy [NI]);
        mi = m; compression_rounds = c; mi_valid = 1'b1;
        @(posedge clk); #1;
        mi_valid = 1'b0;
        m_compress(m, int'(c));
        wait_idle(busy);
    endtask

    task automatic do_fin(input logic [3:0] d, input bit use_const, input logic [127:0] cexp,
                          output int busy [NI]);
        logic [127:0] mexp;
        final_rounds = d; finalize = 1'b1;
        @(posedge clk); #1;
        finalize = 1'b0;
        mexp = m_finalize(int'(d));
        exp_q.push_back(use_const ? cexp : mexp);
        wait_idle(busy);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; initalize = 1'b0; mi_valid = 1'b0; finalize = 1'b0; long = 1'b0;
        mi = '0; compression_rounds = '0; final_rounds = '0; key = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (rdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready p=%0d: got %b want 1", pv[i], rdy[i]); end
            n_checks++;
            if (mrdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_mi_ready p=%0d: got %b want 1", pv[i], mrdy[i]); end
            n_checks++;
            if (vld[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid p=%0d: got %b want 0", pv[i], vld[i]); end
            n_checks++;
            if (word[i] !== 128'h0) begin n_fail++; $display("FAIL reset_word p=%0d: got %h want 0", pv[i], word[i]); end
        end
    endtask

    task automatic test_std_vector(input string tag);
        int bc [NI];
        int bf [NI];
        logic [127:0] exp;
        do_init(KEY_STD, 1'b0);
        do_word(64'h0, 4'd2, bc);
        do_fin(4'd4, 1'b1, 128'h0000000000000000_726fdb47dd0e0e31, bf);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (bc[i] != busy_of(2, pv[i])) begin n_fail++; $display("FAIL %s_comp_busy p=%0d: got %0d want %0d", tag, pv[i], bc[i], busy_of(2, pv[i])); end
            n_checks++;
            if (bf[i] != busy_of(4, pv[i])) begin n_fail++; $display("FAIL %s_fin_busy p=%0d: got %0d want %0d", tag, pv[i], bf[i], busy_of(4, pv[i])); end
        end
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL %s_scoreboard: got empty queue want 1 entry", tag); end
        else begin
            exp = exp_q.pop_front(); last_exp = exp;
            for (int i = 0; i < NI; i++) begin
                $display("txn %s p=%0d word=%h valid=%b", tag, pv[i], word[i], vld[i]);
                n_checks++;
                if (vld[i] !== 1'b1 || word[i] !== exp) begin n_fail++; $display("FAIL %s_digest p=%0d: got v=%b %h want v=1 %h", tag, pv[i], vld[i], word[i], exp); end
            end
        end
    endtask

    task automatic test_multi_word();
        int bc0 [NI];
        int bc1 [NI];
        int bf [NI];
        logic [127:0] exp;
        do_init(KEY_ALT, 1'b0);
        do_word(64'h0706050403020100, 4'd3, bc0);
        do_word(64'h0f0e0d0c0b0a0908, 4'd0, bc1);
        do_fin(4'd5, 1'b0, '0, bf);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (bc0[i] != busy_of(3, pv[i])) begin n_fail++; $display("FAIL multi_comp3_busy p=%0d: got %0d want %0d", pv[i], bc0[i], busy_of(3, pv[i])); end
            n_checks++;
            if (bc1[i] != 1) begin n_fail++; $display("FAIL multi_comp0_busy p=%0d: got %0d want 1", pv[i], bc1[i]); end
            n_checks++;
            if (bf[i] != busy_of(5, pv[i])) begin n_fail++; $display("FAIL multi_fin_busy p=%0d: got %0d want %0d", pv[i], bf[i], busy_of(5, pv[i])); end
        end
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL multi_scoreboard: got empty queue want 1 entry"); end
        else begin
            exp = exp_q.pop_front(); last_exp = exp;
            for (int i = 0; i < NI; i++) begin
                $display("txn multi p=%0d word=%h valid=%b", pv[i], word[i], vld[i]);
                n_checks++;
                if (vld[i] !== 1'b1 || word[i] !== exp) begin n_fail++; $display("FAIL multi_digest p=%0d: got v=%b %h want v=1 %h", pv[i], vld[i], word[i], exp); end
            end
        end
    endtask

    task automatic test_priority();
        int bc [NI];
        int bf [NI];
        logic [127:0] exp;
        key = KEY_ALT; long = 1'b0;
        mi = 64'hdeadbeefcafef00d; compression_rounds = 4'd3; final_rounds = 4'd3;
        initalize = 1'b1; mi_valid = 1'b1; finalize = 1'b1;
        @(posedge clk); #1;
        initalize = 1'b0; mi_valid = 1'b0; finalize = 1'b0;
        m_init(KEY_ALT, 1'b0);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (rdy[i] !== 1'b1 || vld[i] !== 1'b0) begin n_fail++; $display("FAIL prio_state p=%0d: got ready=%b valid=%b want ready=1 valid=0", pv[i], rdy[i], vld[i]); end
        end
        do_word(64'h0800000000000000, 4'd2, bc);
        do_fin(4'd3, 1'b0, '0, bf);
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL prio_scoreboard: got empty queue want 1 entry"); end
        else begin
            exp = exp_q.pop_front(); last_exp = exp;
            for (int i = 0; i < NI; i++) begin
                $display("txn prio p=%0d word=%h valid=%b", pv[i], word[i], vld[i]);
                n_checks++;
                if (vld[i] !== 1'b1 || word[i] !== exp) begin n_fail++; $display("FAIL prio_digest p=%0d: got v=%b %h want v=1 %h", pv[i], vld[i], word[i], exp); end
            end
        end
    endtask

    task automatic test_busy_mi_and_c_change();
        int bc [NI];
        int bf [NI];
        logic [127:0] exp;
        do_init(KEY_STD, 1'b0);
        mi = 64'ha5a5a5a55a5a5a5a; compression_rounds = 4'd8; mi_valid = 1'b1;
        @(posedge clk); #1;
        mi = 64'h1111111111111111;
        for (int cyc = 0; cyc < 2; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (mrdy[i] !== 1'b0) begin n_fail++; $display("FAIL busy_mi_ready p=%0d cyc=%0d: got %b want 0", pv[i], cyc, mrdy[i]); end
            end
            if (cyc == 0) begin @(posedge clk); #1; end
        end
        mi_valid = 1'b0;
        m_compress(64'ha5a5a5a55a5a5a5a, 8);
        wait_idle(bc);
        // Round count changes while the next word is being compressed
        mi = 64'h1122334455667788; compression_rounds = 4'd2; mi_valid = 1'b1;
        @(posedge clk); #1;
        mi_valid = 1'b0; compression_rounds = 4'd15;
        m_compress(64'h1122334455667788, 2);
        wait_idle(bc);
        compression_rounds = 4'd2;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (bc[i] != busy_of(2, pv[i])) begin n_fail++; $display("FAIL cchange_busy p=%0d: got %0d want %0d", pv[i], bc[i], busy_of(2, pv[i])); end
        end
        do_fin(4'd3, 1'b0, '0, bf);
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL cchange_scoreboard: got empty queue want 1 entry"); end
        else begin
            exp = exp_q.pop_front(); last_exp = exp;
            for (int i = 0; i < NI; i++) begin
                $display("txn cchange p=%0d word=%h valid=%b", pv[i], word[i], vld[i]);
                n_checks++;
                if (vld[i] !== 1'b1 || word[i] !== exp) begin n_fail++; $display("FAIL cchange_digest p=%0d: got v=%b %h want v=1 %h", pv[i], vld[i], word[i], exp); end
            end
        end
    endtask

    task automatic test_valid_hold();
        int bc [NI];
        do_word(64'h0123012301230123, 4'd2, bc);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (vld[i] !== 1'b1 || word[i] !== last_exp) begin n_fail++; $display("FAIL hold_after_comp p=%0d: got v=%b %h want v=1 %h", pv[i], vld[i], word[i], last_exp); end
        end
        do_init(KEY_STD, 1'b0);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (vld[i] !== 1'b0) begin n_fail++; $display("FAIL hold_init_clears p=%0d: got %b want 0", pv[i], vld[i]); end
        end
    endtask

    task automatic test_long();
        int bc [NI];
        int bf [NI];
        int m;
        logic [127:0] exp;
        do_init(KEY_STD, 1'b1);
        do_word(64'h0, 4'd2, bc);
        do_fin(4'd4, 1'b1, EN128 ? 128'h930255c71472f66d_e6a825ba047f81a3
                                 : 128'h0000000000000000_726fdb47dd0e0e31, bf);
        for (int i = 0; i < NI; i++) begin
            m = (4 + pv[i] - 1) / pv[i];
            n_checks++;
            if (bf[i] != (EN128 ? 2 * m + 2 : m + 1)) begin n_fail++; $display("FAIL long_fin_busy p=%0d: got %0d want %0d", pv[i], bf[i], EN128 ? 2 * m + 2 : m + 1); end
        end
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL long_scoreboard: got empty queue want 1 entry"); end
        else begin
            exp = exp_q.pop_front(); last_exp = exp;
            for (int i = 0; i < NI; i++) begin
                $display("txn long p=%0d word=%h valid=%b", pv[i], word[i], vld[i]);
                n_checks++;
                if (vld[i] !== 1'b1 || word[i] !== exp) begin n_fail++; $display("FAIL long_digest p=%0d: got v=%b %h want v=1 %h", pv[i], vld[i], word[i], exp); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bc [NI];
        do_init(KEY_STD, 1'b1);
        do_word(64'h0, 4'd2, bc);
        final_rounds = 4'd4; finalize = 1'b1;
        @(posedge clk); #1;
        finalize = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (rdy[i] !== 1'b1 || mrdy[i] !== 1'b1 || vld[i] !== 1'b0 || word[i] !== 128'h0) begin
                n_fail++;
                $display("FAIL midreset_outputs p=%0d: got rdy=%b mrdy=%b v=%b %h want 1 1 0 0", pv[i], rdy[i], mrdy[i], vld[i], word[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_std_vector("std");
        test_multi_word();
        test_priority();
        test_busy_mi_and_c_change();
        test_valid_hold();
        test_long();
        test_reset_mid();
        test_std_vector("after_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/siphash_pcore.md
# siphash_pcore

Parametrised SipHash core, the next generation of the single-round SipHash core. It performs up to `ROUNDS_PER_CYCLE` SipRounds per clock and latches round counts at command accept. Message words use a valid/ready handshake. A compile-time option adds true SipHash-128 output (second finalization pass). It keeps the same command/word-level position between the top-level API wrapper and the datapath, so existing wrappers drive it with only the handshake added.

## Interface
- `ROUNDS_PER_CYCLE`, 1: SipRounds applied per round cycle; legal 1..4.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `initalize`  in  1  command: load key-derived state; accepted only when `ready`=1.
- `mi_valid`  in  1  message word offered; accepted when `mi_valid`&`mi_ready`.
- `mi`  in  64  little-endian message word (final word carries length byte in [63:56]).
- `mi_ready`  out  1  core can take a message word; equals `ready`.
- `finalize`  in  1  command: run finalization; accepted only when `ready`=1.
- `long`  in  1  128-bit output mode; sampled at `initalize` accept.
- `compression_rounds`  in  4  c; latched at each `mi` accept.
- `final_rounds`  in  4  d; latched at `finalize` accept.
- `key`  in  128  k1 in [127:64], k0 in [63:0].
- `ready`  out  1  idle, no operation in progress.
- `siphash_word`  out  128  result; [63:0] first output word, [127:64] second word (0 in 64-bit mode).
- `siphash_word_valid`  out  1  result valid.

## Operation
- Reset values: `ready`=1, `mi_ready`=1, `siphash_word`=0, `siphash_word_valid`=0, v0..v3=0, long_reg=0, all counters 0, FSM=IDLE. Reset mid-operation aborts immediately. No partial result is kept.
- IDLE priority when several requests are active in the same cycle: `initalize` > `mi_valid` > `finalize`. Requests while `ready`=0 are ignored; `mi_ready`=0 in that case.
- Init (1 cycle, stays IDLE):
  - v0=k0^736f6d6570736575, v1=k1^646f72616e646f6d, v2=k0^6c7967656e657261, v3=k1^7465646279746573.
  - If long then v1 ^= 0xee.
  - `siphash_word_valid` cleared.
- Compress:
  - Accept edge: v3^=mi, latch mi and c, rem=c, go COMP.
  - COMP: each cycle applies k=min(P,rem) rounds, then rem-=k. When rem reaches 0, go COMP_END.
  - COMP_END: v0^=mi_reg, `ready`=1, go IDLE.
  - c=0 goes straight from accept to COMP_END.
- Finalize:
  - Accept edge: v2^=(long?0xee:0xff), latch d, rem=d, valid cleared, go FIN.
  - FIN: each cycle applies min(P,rem) rounds; rem=0 leads to FIN_END.
  - FIN_END: capture word[63:0]=v0^v1^v2^v3.
    - Not long: word[127:64]=0, valid=1, ready=1, go IDLE.
    - Long: v1^=0xdd, rem=d, go FIN2.
  - FIN2: rounds as in FIN, then FIN2_END.
  - FIN2_END: word[127:64]=v0^v1^v2^v3, valid=1, ready=1, go IDLE.
- States: IDLE, COMP, COMP_END, FIN, FIN_END, FIN2, FIN2_END.
- Round datapath: chain of P SipRound stages. Stage i is bypassed when i ≥ k. All arithmetic is mod 2^64.
- Round counts are 4-bit unsigned, 0..15. Latched values are immune to input changes mid-operation.

## Timing
- Define N=ceil(c/P) and M=ceil(d/P).
- Compress: accept at edge 0, rounds on edges 1..N, COMP_END on edge N+1. `ready` is low for N+1 cycles. The next word can be accepted on the edge after `ready` returns to 1.
- Finalize (64-bit): rounds on edges 1..M, FIN_END on edge M+1. `ready`/`siphash_word_valid` are 1 after edge M+1.
- Finalize (128-bit): `ready`/`siphash_word_valid` are 1 after edge 2M+2. word[63:0] updates at edge M+1 while valid is still 0.
- Init: 0 busy cycles; `ready` stays 1.
- `siphash_word_valid` holds until the next `initalize` or `finalize` accept.

## Configuration
- `SIPHASH_128_EN`
  - Defined: `long` behaves as above, and FIN2/FIN2_END are present.
  - Undefined: `long` is ignored (treated as 0), no 0xee/0xdd tweaks, FIN2 states are not synthesised, and word[127:64] is constant 0.

## Structure
- `siphash_pkg`: IV constants, 0xee/0xff/0xdd tweak constants, FSM state encodings, `sipround` state typedef (four 64-bit words).
- Sub-module `siphash_round`: combinational single SipRound. It is instantiated P times in the bypassable chain.

## Test plan
- key=0f0e0d0c0b0a0908_0706050403020100, c=2, d=4, P=1, long=0; init, mi=0, finalize -> siphash_word=0x0000000000000000_726fdb47dd0e0e31, valid=1.
- Same key, empty message, long=1, `SIPHASH_128_EN` defined -> siphash_word=0x930255c71472f66d_e6a825ba047f81a3.
- Latency sweep for c=2, d=4: P=1 gives ready low 3 cycles for compress and 5 for finalize; P=3 gives 2 and 3; P=4 gives 2 and 2. Every P must produce an identical digest.
- Boundary cases:
  - c=0: compress completes in 1 busy cycle.
  - `initalize`+`mi_valid`+`finalize` in the same IDLE cycle: only init is taken, `ready` stays 1.
  - `mi_valid` held while busy: word is not accepted, `mi_ready`=0.
  - Changing `compression_rounds` mid-COMP does not alter the result.
- Deassert `reset_n` during FIN2 -> all outputs are at reset values on the same cycle. A new init plus hash then gives the correct vector.
